// File: rtl/uart_ctrl.sv
`timescale 1ns/1ps
// uart_ctrl: bus-mapped sequencer for the UART TX/RX pair.
// Handshake note: each TX frame is one tx_start pulse followed by a wait for
// tx_done, with no overlap between frames. Each RX byte is taken while rx_irq
// is high, then acknowledged with a single rx_clear pulse. A new byte is not
// accepted until rx_irq has dropped again.
module uart_ctrl #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  input  logic [7:0]  rx_data,
  input  logic        rx_irq,
  input  logic        rx_perr,
  output logic        rx_clear,
  output logic [1:0]  txStateDbg,
  output logic [1:0]  rxStateDbg
);

  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int RXAW = $clog2(RX_DEPTH);
  localparam int TXCW = TXAW + 1;
  localparam int RXCW = RXAW + 1;
  localparam logic [TXCW-1:0] TX_FULL_CNT = TXCW'(TX_DEPTH);
  localparam logic [RXCW-1:0] RX_FULL_CNT = RXCW'(RX_DEPTH);

  typedef enum logic [1:0] {T_IDLE = 2'd0, T_START = 2'd1, T_BUSY = 2'd2} txStateT;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_CLR = 2'd1, R_WAIT = 2'd2} rxStateT;

  txStateT txState;
  rxStateT rxState;

  // FIFO storage and bookkeeping
  logic [7:0]      txMem [TX_DEPTH];
  logic [TXAW-1:0] txWrPtr, txRdPtr;
  logic [TXCW-1:0] txCount;
  logic [8:0]      rxMem [RX_DEPTH];
  logic [RXAW-1:0] rxWrPtr, rxRdPtr;
  logic [RXCW-1:0] rxCount;

  // Control / sticky status
  logic ieRx, ieTx;
  logic overrun, perrSeen;

  // Bus decode
  logic wrTx, wrStatus, wrCtrl, rdRx, flush;
  logic txFull, txEmpty, rxFull, rxEmpty, txBusy;
  logic txPush, txPop, rxPushReq, rxPush, rxPop, overrunSet, perrSet;
  logic [31:0] statusWord;
  logic unusedBits;

  assign wrTx     = sel & we & (addr == 2'd0);
  assign wrStatus = sel & we & (addr == 2'd2);
  assign wrCtrl   = sel & we & (addr == 2'd3);
  assign rdRx     = sel & ~we & (addr == 2'd1);
  assign flush    = wrCtrl & wdata[2];

  assign txFull  = (txCount == TX_FULL_CNT);
  assign txEmpty = (txCount == '0);
  assign rxFull  = (rxCount == RX_FULL_CNT);
  assign rxEmpty = (rxCount == '0);
  assign txBusy  = (txState != T_IDLE);

  // The TX FSM drains the FIFO only from idle; a write into a full FIFO
  // survives when that same edge frees a slot.
  assign txPop  = (txState == T_IDLE) & ~txEmpty;
  assign txPush = wrTx & (~txFull | txPop);

  // RX capture happens once per rx_irq assertion, on the idle-state edge.
  assign rxPushReq  = (rxState == R_IDLE) & rx_irq;
  assign rxPop      = rdRx & ~rxEmpty;
  assign rxPush     = rxPushReq & (~rxFull | rxPop);
  assign overrunSet = rxPushReq & rxFull & ~rxPop;
  assign perrSet    = rxPushReq & rx_perr;

  assign unusedBits = &{1'b0, wdata[31:8]};

  assign statusWord = {25'b0, perrSeen, overrun, txBusy, rxFull, rxEmpty, txEmpty, txFull};

  assign irq = (ieRx & ~rxEmpty) | (ieTx & txEmpty & ~txBusy) | (ieRx & overrun);

  assign txStateDbg = txState;
  assign rxStateDbg = rxState;

  // TX FIFO data array (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (txPush) txMem[txWrPtr] <= wdata[7:0];
  end

  // TX FIFO pointers and occupancy; flush clears occupancy only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txWrPtr <= '0;
      txRdPtr <= '0;
      txCount <= '0;
    end else if (flush) begin
      txWrPtr <= '0;
      txRdPtr <= '0;
      txCount <= '0;
    end else begin
      if (txPush) txWrPtr <= txWrPtr + TXAW'(1);
      if (txPop)  txRdPtr <= txRdPtr + TXAW'(1);
      case ({txPush, txPop})
        2'b10:   txCount <= txCount + TXCW'(1);
        2'b01:   txCount <= txCount - TXCW'(1);
        default: txCount <= txCount;
      endcase
    end
  end

  // RX FIFO data array: {parity error, byte}
  always_ff @(posedge clk) begin
    if (rxPush) rxMem[rxWrPtr] <= {rx_perr, rx_data};
  end

  // RX FIFO pointers and occupancy; flush clears occupancy only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxWrPtr <= '0;
      rxRdPtr <= '0;
      rxCount <= '0;
    end else if (flush) begin
      rxWrPtr <= '0;
      rxRdPtr <= '0;
      rxCount <= '0;
    end else begin
      if (rxPush) rxWrPtr <= rxWrPtr + RXAW'(1);
      if (rxPop)  rxRdPtr <= rxRdPtr + RXAW'(1);
      case ({rxPush, rxPop})
        2'b10:   rxCount <= rxCount + RXCW'(1);
        2'b01:   rxCount <= rxCount - RXCW'(1);
        default: rxCount <= rxCount;
      endcase
    end
  end

  // TX sequencer: pop one byte, pulse tx_start, hold tx_data until tx_done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txState  <= T_IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      case (txState)
        T_IDLE: begin
          tx_start <= 1'b0;
          if (!txEmpty) begin
            tx_data  <= txMem[txRdPtr];
            tx_start <= 1'b1;
            txState  <= T_START;
          end
        end
        T_START: begin
          tx_start <= 1'b0;
          txState  <= T_BUSY;
        end
        T_BUSY: begin
          tx_start <= 1'b0;
          if (tx_done) txState <= T_IDLE;
        end
        default: begin
          tx_start <= 1'b0;
          txState  <= T_IDLE;
        end
      endcase
    end
  end

  // RX sequencer: capture on rx_irq, pulse rx_clear, wait for rx_irq to drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxState  <= R_IDLE;
      rx_clear <= 1'b0;
    end else begin
      case (rxState)
        R_IDLE: begin
          rx_clear <= 1'b0;
          if (rx_irq) begin
            rx_clear <= 1'b1;
            rxState  <= R_CLR;
          end
        end
        R_CLR: begin
          rx_clear <= 1'b0;
          rxState  <= R_WAIT;
        end
        R_WAIT: begin
          rx_clear <= 1'b0;
          if (!rx_irq) rxState <= R_IDLE;
        end
        default: begin
          rx_clear <= 1'b0;
          rxState  <= R_IDLE;
        end
      endcase
    end
  end

  // Sticky flags: a new event beats a same-cycle write-one-to-clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun  <= 1'b0;
      perrSeen <= 1'b0;
    end else begin
      if (overrunSet)                 overrun <= 1'b1;
      else if (wrStatus && wdata[5])  overrun <= 1'b0;
      if (perrSet)                    perrSeen <= 1'b1;
      else if (wrStatus && wdata[6])  perrSeen <= 1'b0;
    end
  end

  // Interrupt enables; flush bit is not stored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ieRx <= 1'b0;
      ieTx <= 1'b0;
    end else if (wrCtrl) begin
      ieRx <= wdata[0];
      ieTx <= wdata[1];
    end
  end

  // Read mux: zero unless a read is selected; RXDATA shows the FIFO head
  always_comb begin
    rdata = 32'h0;
    if (sel && !we) begin
      case (addr)
        2'd1:    if (!rxEmpty) rdata = {23'b0, rxMem[rxRdPtr]};
        2'd2:    rdata = statusWord;
        2'd3:    rdata = {30'b0, ieTx, ieRx};
        default: rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
`timescale 1ns/1ps
// tb_uart_ctrl: register vector table plus TX/RX sequences for uart_ctrl.
module tb_uart_ctrl;

  localparam int TX_DEPTH = 4;
  localparam int RX_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel, we;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic        irq, txStart, txDone, rxIrq, rxPerr, rxClear;
  logic [7:0]  txData, rxData;
  logic [1:0]  txStateDbg, rxStateDbg;

  int vecCount = 0;
  int missCount = 0;

  logic [7:0] txExpQ[$];
  logic [7:0] txObsQ[$];
  logic [8:0] rxExpQ[$];
  int   widthErr = 0;
  logic prevStart = 1'b0;
  bit   respEn = 1'b1;
  int   respDelay = 10;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] expRd;
    logic        expIrq;
    string       name;
  } vecT;
  vecT vecs[14];

  uart_ctrl #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq(irq), .tx_start(txStart), .tx_data(txData),
    .tx_done(txDone), .rx_data(rxData), .rx_irq(rxIrq), .rx_perr(rxPerr),
    .rx_clear(rxClear), .txStateDbg(txStateDbg), .rxStateDbg(rxStateDbg)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // TX monitor: records each launched byte and flags multi-cycle pulses
  initial begin
    forever begin
      @(negedge clk);
      if (rst && txStart) begin
        txObsQ.push_back(txData);
        if (prevStart) widthErr++;
      end
      prevStart = txStart;
    end
  end

  // UART transmitter model: tx_done pulse respDelay cycles after tx_start
  initial begin
    txDone = 1'b0;
    forever begin
      @(negedge clk);
      if (txStart && respEn) begin
        repeat (respDelay) @(posedge clk);
        #1 txDone = 1'b1;
        @(posedge clk);
        #1 txDone = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; wdata = 32'h0;
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] d, output logic irqS);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    irqS = irq;
    @(posedge clk); #1;
    sel = 1'b0;
  endtask

  task automatic checkStatus(input string name, input logic [31:0] exp);
    logic [31:0] d;
    logic i;
    busRead(2'd2, d, i);
    check(name, d, exp);
  endtask

  task automatic readRx(input string name);
    logic [31:0] d;
    logic [31:0] exp;
    logic i;
    exp = 32'h0;
    if (rxExpQ.size() > 0) exp = {23'b0, rxExpQ.pop_front()};
    busRead(2'd1, d, i);
    check(name, d, exp);
  endtask

  task automatic pushTx(input logic [7:0] b);
    txExpQ.push_back(b);
    busWrite(2'd0, {24'h0, b});
  endtask

  task automatic rxFrame(input logic [7:0] d, input logic p);
    rxData = d; rxPerr = p; rxIrq = 1'b1;
    if (rxExpQ.size() < RX_DEPTH) rxExpQ.push_back({p, d});
    @(posedge clk); #1;
    check("rx_clear_hi", rxClear, 1);
    rxIrq = 1'b0; rxPerr = 1'b0;
    @(posedge clk); #1;
    check("rx_clear_lo", rxClear, 0);
    @(posedge clk); #1;
  endtask

  task automatic waitTxIdle(input int nObs, input string name);
    int n = 0;
    while ((txObsQ.size() < nObs || txStateDbg != 2'd0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, (n < 3000), 1);
  endtask

  task automatic checkTx();
    logic [7:0] obs;
    while (txObsQ.size() > 0) begin
      obs = txObsQ.pop_front();
      if (txExpQ.size() == 0) begin
        vecCount++;
        missCount++;
        $display("FAIL tx_extra: got 0x%0h expected no frame", obs);
      end else begin
        check("tx_byte", obs, txExpQ.pop_front());
      end
    end
    check("tx_missing", txExpQ.size(), 0);
    txExpQ.delete();
    check("tx_width", widthErr, 0);
  endtask

  initial begin
    logic [31:0] d;
    logic        i;

    vecs[0]  = '{1'b0, 2'd2, 32'h0,        32'h06, 1'b0, "rst_status"};
    vecs[1]  = '{1'b0, 2'd3, 32'h0,        32'h00, 1'b0, "rst_control"};
    vecs[2]  = '{1'b0, 2'd0, 32'h0,        32'h00, 1'b0, "rd_txdata"};
    vecs[3]  = '{1'b0, 2'd1, 32'h0,        32'h00, 1'b0, "rd_rx_empty"};
    vecs[4]  = '{1'b1, 2'd3, 32'h3,        32'h00, 1'b1, "wr_ctrl_ie"};
    vecs[5]  = '{1'b0, 2'd3, 32'h0,        32'h03, 1'b1, "rd_ctrl_ie"};
    vecs[6]  = '{1'b1, 2'd3, 32'hFFFFFFF9, 32'h00, 1'b0, "wr_ctrl_rxonly"};
    vecs[7]  = '{1'b0, 2'd3, 32'h0,        32'h01, 1'b0, "rd_ctrl_rxonly"};
    vecs[8]  = '{1'b1, 2'd1, 32'hAB,       32'h00, 1'b0, "wr_rxdata"};
    vecs[9]  = '{1'b0, 2'd2, 32'h0,        32'h06, 1'b0, "status_after_rxwr"};
    vecs[10] = '{1'b1, 2'd2, 32'hFFFFFFFF, 32'h00, 1'b0, "w1c_none_set"};
    vecs[11] = '{1'b0, 2'd2, 32'h0,        32'h06, 1'b0, "status_after_w1c"};
    vecs[12] = '{1'b1, 2'd3, 32'h0,        32'h00, 1'b0, "wr_ctrl_zero"};
    vecs[13] = '{1'b0, 2'd3, 32'h0,        32'h00, 1'b0, "rd_ctrl_zero"};

    // reset
    sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'h0;
    rxData = 8'h0; rxIrq = 1'b0; rxPerr = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // register vectors
    for (int k = 0; k < 14; k++) begin
      if (vecs[k].we) begin
        busWrite(vecs[k].addr, vecs[k].wdata);
        check({vecs[k].name, "_irq"}, irq, vecs[k].expIrq);
      end else begin
        busRead(vecs[k].addr, d, i);
        check(vecs[k].name, d, vecs[k].expRd);
        check({vecs[k].name, "_irq"}, i, vecs[k].expIrq);
      end
    end

    // TX single frame with latency check
    respEn = 1'b1;
    respDelay = 100;
    pushTx(8'h41);
    check("tx_lat_n", txStart, 0);
    @(posedge clk); #1;
    check("tx_lat_n1", txStart, 1);
    check("tx_data_41", txData, 8'h41);
    @(posedge clk); #1;
    check("tx_start_drop", txStart, 0);
    check("tx_data_hold", txData, 8'h41);
    checkStatus("status_tx_busy", 32'h16);
    waitTxIdle(1, "tx_single_done");
    checkStatus("status_tx_idle", 32'h06);
    checkTx();

    // TX fill: five accepted, sixth dropped while full
    respDelay = $urandom_range(8, 20);
    for (int b = 0; b < 5; b++) pushTx(8'h10 + 8'(b));
    busWrite(2'd0, 32'h15);
    checkStatus("status_tx_full", 32'h15);
    waitTxIdle(5, "tx_fill_done");
    repeat (40) @(posedge clk);
    #1;
    checkStatus("status_tx_drained", 32'h06);
    checkTx();

    // IRQ from ie_tx
    respDelay = $urandom_range(10, 30);
    busWrite(2'd3, 32'h2);
    check("irq_tx_idle", irq, 1);
    pushTx(8'h33);
    check("irq_tx_pending", irq, 0);
    @(posedge clk); #1;
    check("irq_tx_start", irq, 0);
    waitTxIdle(1, "irq_tx_done");
    check("irq_tx_back", irq, 1);
    busWrite(2'd3, 32'h0);
    checkTx();

    // RX single byte
    rxFrame(8'h5A, 1'b0);
    checkStatus("status_rx_one", 32'h02);
    readRx("rx_5a");
    checkStatus("status_rx_empty", 32'h06);

    // RX overrun with parity error on the dropped frame
    for (int b = 0; b < 4; b++) rxFrame(8'h81 + 8'(b), 1'b0);
    checkStatus("status_rx_full", 32'h0A);
    rxFrame(8'h85, 1'b1);
    checkStatus("status_overrun", 32'h6A);
    busWrite(2'd3, 32'h1);
    check("irq_rx", irq, 1);
    busWrite(2'd3, 32'h0);
    busWrite(2'd2, 32'h20);
    checkStatus("status_w1c_ovr", 32'h4A);
    for (int b = 0; b < 4; b++) readRx("rx_fifo_byte");
    readRx("rx_after_drain");
    checkStatus("status_perr_only", 32'h46);
    busWrite(2'd2, 32'h40);
    checkStatus("status_w1c_perr", 32'h06);

    // flush empties RX without touching enables
    rxFrame(8'h21, 1'b0);
    rxFrame(8'h22, 1'b1);
    checkStatus("status_pre_flush", 32'h42);
    busWrite(2'd3, 32'h4);
    rxExpQ.delete();
    checkStatus("status_flushed", 32'h46);
    busRead(2'd3, d, i);
    check("ctrl_after_flush", d, 32'h0);
    readRx("rx_after_flush");
    busWrite(2'd2, 32'h40);

    // asynchronous reset mid-frame
    respEn = 1'b0;
    busWrite(2'd3, 32'h3);
    rxFrame(8'h11, 1'b0);
    pushTx(8'h77);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_before_rst", txStateDbg, 2'd2);
    check("irq_before_rst", irq, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_tx_start", txStart, 0);
    check("rst_tx_data", txData, 8'h00);
    check("rst_irq", irq, 0);
    sel = 1'b1; we = 1'b0; addr = 2'd2;
    #1;
    check("rst_status_async", rdata, 32'h06);
    addr = 2'd3;
    #1;
    check("rst_ctrl_async", rdata, 32'h0);
    sel = 1'b0;
    rxExpQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkTx();
    repeat (5) @(posedge clk);
    #1;
    checkStatus("status_post_rst", 32'h06);
    readRx("rx_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
